// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the transmitter and the receiver.
package uart_pkg;

   localparam int DATA_BITS = 8;

   // Must agree between transmitter and receiver: 9600 baud at 50 MHz.
   localparam logic [12:0] DEFAULT_BAUD_CNT_MAX = 13'd5207;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Parallel output bundle of the UART receiver; same byte format the transmitter accepts.
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] po_data;
   logic                 po_flag;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (
      output po_data,
      output po_flag,
      output frame_err,
      output rx_busy
   );

   modport slave (
      input po_data,
      input po_flag,
      input frame_err,
      input rx_busy
   );

endinterface

// File: rtl/uart_rx_sync.sv
// Three-flop synchroniser for the asynchronous rx line with falling-edge detect.
module uart_rx_sync (
   input  logic sys_clk,
   input  logic sys_rst_n,
   input  logic rx,
   output logic rx_s2,
   output logic fall
);

   logic rx_s1;
   logic rx_s3;

   // Reset to idle-high so no false edge appears out of reset.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         rx_s1 <= 1'b1;
         rx_s2 <= 1'b1;
         rx_s3 <= 1'b1;
      end else begin
         rx_s1 <= rx;
         rx_s2 <= rx_s1;
         rx_s3 <= rx_s2;
      end
   end

   assign fall = rx_s3 & ~rx_s2;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling of the synchronised rx line, one byte per good frame.
module uart_rx
   import uart_pkg::*;
#(
   parameter logic [12:0] BAUD_CNT_MAX = DEFAULT_BAUD_CNT_MAX
) (
   input  logic       sys_clk,
   input  logic       sys_rst_n,
   input  logic       rx,
   uart_rx_if.master  rx_bus
);

   localparam logic [12:0] HALF = BAUD_CNT_MAX >> 1;

   logic                 rx_s2;
   logic                 fall;
   logic                 mid_s;
   state_t               state_r;
   state_t               next_state_s;
   logic [12:0]          baud_cnt_r;
   logic [12:0]          baud_cnt_nxt_s;
   logic [2:0]           bit_cnt_r;
   logic [2:0]           bit_cnt_nxt_s;
   logic [DATA_BITS-1:0] shift_r;
   logic [DATA_BITS-1:0] shift_nxt_s;
   logic [DATA_BITS-1:0] po_data_r;
   logic [DATA_BITS-1:0] po_data_nxt_s;
   logic                 po_flag_r;
   logic                 po_flag_nxt_s;
   logic                 frame_err_r;
   logic                 frame_err_nxt_s;
   logic                 rx_busy_r;

   uart_rx_sync u_sync (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .rx        (rx),
      .rx_s2     (rx_s2),
      .fall      (fall)
   );

   assign mid_s = (baud_cnt_r == HALF);

   // Next-state, shift register, bit counter and output pulse decode.
   always_comb begin
      next_state_s    = state_r;
      bit_cnt_nxt_s   = bit_cnt_r;
      shift_nxt_s     = shift_r;
      po_data_nxt_s   = po_data_r;
      po_flag_nxt_s   = 1'b0;
      frame_err_nxt_s = 1'b0;
      case (state_r)
         IDLE: begin
            if (fall) begin
               next_state_s = START;
            end else begin
               next_state_s = IDLE;
            end
         end
         START: begin
            if (mid_s) begin
               // A start bit that is high again at mid-bit was a glitch.
               if (!rx_s2) begin
                  next_state_s  = DATA;
                  bit_cnt_nxt_s = 3'd0;
               end else begin
                  next_state_s  = IDLE;
               end
            end else begin
               next_state_s = START;
            end
         end
         DATA: begin
            if (mid_s) begin
               shift_nxt_s = {rx_s2, shift_r[DATA_BITS-1:1]};
               if (bit_cnt_r == 3'd7) begin
                  next_state_s = STOP;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + 3'd1;
               end
            end else begin
               next_state_s = DATA;
            end
         end
         STOP: begin
            if (mid_s) begin
               // Leaving at mid-stop gives half a bit to catch a back-to-back start edge.
               next_state_s = IDLE;
               if (rx_s2) begin
                  po_data_nxt_s = shift_r;
                  po_flag_nxt_s = 1'b1;
               end else begin
                  frame_err_nxt_s = 1'b1;
               end
            end else begin
               next_state_s = STOP;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   // Baud counter: held at zero in IDLE so START always begins from zero.
   always_comb begin
      baud_cnt_nxt_s = 13'd0;
      if ((state_r == IDLE) || (next_state_s == IDLE)) begin
         baud_cnt_nxt_s = 13'd0;
      end else if (baud_cnt_r == BAUD_CNT_MAX) begin
         baud_cnt_nxt_s = 13'd0;
      end else begin
         baud_cnt_nxt_s = baud_cnt_r + 13'd1;
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_r     <= IDLE;
         baud_cnt_r  <= 13'd0;
         bit_cnt_r   <= 3'd0;
         shift_r     <= '0;
         po_data_r   <= '0;
         po_flag_r   <= 1'b0;
         frame_err_r <= 1'b0;
         rx_busy_r   <= 1'b0;
      end else begin
         state_r     <= next_state_s;
         baud_cnt_r  <= baud_cnt_nxt_s;
         bit_cnt_r   <= bit_cnt_nxt_s;
         shift_r     <= shift_nxt_s;
         po_data_r   <= po_data_nxt_s;
         po_flag_r   <= po_flag_nxt_s;
         frame_err_r <= frame_err_nxt_s;
         rx_busy_r   <= (next_state_s != IDLE);
      end
   end

   assign rx_bus.po_data   = po_data_r;
   assign rx_bus.po_flag   = po_flag_r;
   assign rx_bus.frame_err = frame_err_r;
   assign rx_bus.rx_busy   = rx_busy_r;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the downstream consumer of the UART transmitter's `tx` line. It handles 8N1 frames: one low start bit, 8 data bits LSB first, one high stop bit, at a bit period of BAUD_CNT_MAX+1 sys_clk cycles. It synchronises the asynchronous `rx` line, validates the start bit at mid-bit, samples each data bit at mid-bit, and checks the stop bit. For each good frame it presents one byte with a single-cycle `po_flag`, the same parallel format the transmitter accepts on `pi_data`/`pi_data_flag`. This allows direct loopback.

## Interface
- BAUD_CNT_MAX, 13'd5207: last value of the baud counter, which runs 0..BAUD_CNT_MAX (9600 baud at 50 MHz). Must match the transmitter.
- sys_clk  input  1  clock
- sys_rst_n  input  1  reset, asynchronous, active-low
- rx  input  1  serial line, asynchronous to sys_clk, idle high
- po_data  output  8  last correctly received byte
- po_flag  output  1  one-cycle pulse: po_data updated this cycle
- frame_err  output  1  one-cycle pulse: stop bit sampled low, byte discarded
- rx_busy  output  1  high while the FSM is not in IDLE

## Operation
- Input synchroniser:
  - `rx` passes through 3 flops: rx_s1, rx_s2, rx_s3. rx_s1 and rx_s2 form the metastability pair.
  - All samples are taken from rx_s2.
  - Falling edge is `fall = rx_s3 & ~rx_s2`.
- Counters:
  - HALF = BAUD_CNT_MAX/2, truncated (2603 at default).
  - baud_cnt is 13 bits. It clears to 0 on entry to START and in IDLE. It increments every cycle otherwise and wraps BAUD_CNT_MAX→0.
  - `mid = (baud_cnt == HALF)`.
  - bit_cnt is 3 bits and counts data bits 0..7.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: when `fall`, go to START with baud_cnt←0.
  - START: on `mid`, if rx_s2=0 go to DATA with bit_cnt←0. If rx_s2=1 the start bit was a glitch: go to IDLE with no output pulse.
  - DATA: on `mid`, do shift←{rx_s2, shift[7:1]} so bits land LSB first. If bit_cnt==7 go to STOP, else bit_cnt++.
  - STOP: on `mid`, always go to IDLE.
    - If rx_s2=1: po_data←shift and po_flag=1 next cycle.
    - If rx_s2=0: frame_err=1 next cycle and po_data is unchanged.
- Returning to IDLE at mid-stop leaves half a bit period to detect the next start edge. Back-to-back frames with one stop bit are therefore received without loss.
- A low `rx` already present when entering IDLE is not a start. Only a 1→0 transition (`fall`) starts a frame. After a framing error, a line held low is ignored until it returns high.
- `rx` activity while not in IDLE is ignored except at `mid` sample points.

## Timing
- Reset values:
  - po_data=8'h00, po_flag=0, frame_err=0, rx_busy=0.
  - FSM=IDLE, baud_cnt=0, bit_cnt=0, shift=0.
  - rx_s1..rx_s3=1, so no false edge is seen out of reset.
- Reset asserted mid-frame aborts immediately and emits no pulse. After release, reception resumes at the next falling edge.
- Edge detection latency: `rx` falls before clock edge k → rx_s2=0 after edge k+1 → FSM in START, baud_cnt=0 after edge k+2.
- Sample points: the start bit is sampled HALF cycles after START entry. Each later sample is BAUD_CNT_MAX+1 cycles after the previous one. There are 10 samples in total.
- po_flag/frame_err:
  - Registered; high for exactly 1 cycle, in the cycle after the stop sample edge.
  - Never both high together.
  - At most one pulse per frame.
- Latency from `rx` falling to po_flag rising: 2 + HALF + 9·(BAUD_CNT_MAX+1) + 1 cycles.
- po_data is stable from the po_flag cycle until the next po_flag.
- rx_busy rises with START entry and falls with IDLE entry.

## Structure
- Shared package `uart_pkg` holds:
  - FSM state localparams (IDLE=2'd0, START=2'd1, DATA=2'd2, STOP=2'd3).
  - DATA_BITS=8.
  - Default BAUD_CNT_MAX=13'd5207, used by both the transmitter and this block.
- One sub-module, `uart_rx_sync`: 3-flop synchroniser producing rx_s2 and `fall`, reset to all-ones.
- Baud counter, bit counter, FSM and output registers stay in `uart_rx`.

## Test plan
Run with BAUD_CNT_MAX=15, so HALF=7 and the bit period is 16 cycles, unless noted.
- Single frame 8'hA5 (line: 0,1,0,1,0,0,1,0,1,1) → one po_flag pulse, po_data=8'hA5, frame_err never high, latency 2+7+144+1=154 cycles from start edge.
- Loopback: transmitter (same BAUD_CNT_MAX) driving `rx`, pi_data sequence 8'h00, 8'hFF, 8'h55, 8'h3C sent back-to-back → four po_flag pulses carrying the same bytes in order, no frame_err.
- Glitch: `rx` low for 4 cycles, then high → rx_busy pulses, no po_flag, no frame_err, FSM back in IDLE. The next valid frame 8'h81 is received correctly.
- Framing error: frame 8'h42 with stop bit driven low, then `rx` held low for 40 cycles, then high → one frame_err pulse, po_data keeps its previous value, no new frame starts until `rx` rises and falls again.
- Reset mid-frame: assert sys_rst_n low during data bit 4 of 8'hC3 → all outputs at reset values, no pulse. After release, frame 8'h7E → po_data=8'h7E.
- Default parameter: one frame 8'h5A at BAUD_CNT_MAX=5207 → po_data=8'h5A, first data sample 2603+5208 cycles after START entry.
